// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised single-clock FIFO.
//   clog2      : ceiling log2 used to size pointers and the occupancy counter
//   cnt_w      : counter width able to hold 0..n_cells
//   ptr_w      : pointer width able to address 0..n_cells-1
//   params_ok  : legality of the FIFO parameter set, checked at elaboration
//   fifo_flags_t : registered status flags derived from the occupancy count
package fifo_pkg;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int cnt_w(input int n_cells);
    return clog2(n_cells + 1);
  endfunction

  function automatic int ptr_w(input int n_cells);
    return (clog2(n_cells) < 1) ? 1 : clog2(n_cells);
  endfunction

  function automatic bit params_ok(input int n_bits, input int n_cells,
                                   input int af_margin, input int ae_margin);
    return (n_bits >= 1) && (n_cells >= 2) &&
           (af_margin >= 0) && (af_margin < n_cells) &&
           (ae_margin >= 0) && (ae_margin < n_cells);
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;

  localparam fifo_flags_t FLAGS_RST = '{full: 1'b0, empty: 1'b1,
                                        almost_full: 1'b0, almost_empty: 1'b1};

endpackage

// File: rtl/fifo_sync_param_if.sv
// Put/get handshake bundle of the single-clock FIFO.
//   master : the producer/consumer side (drives requests, flush, clr_err)
//   slave  : the FIFO side (drives read data, status flags and error flags)
interface fifo_sync_param_if #(
  parameter int N_BITS = 32,
  parameter int CNT_W  = 5
);
  logic              req_put;
  logic [N_BITS-1:0] data_put;
  logic              req_get;
  logic [N_BITS-1:0] data_get;
  logic              valid_get;
  logic              full_out;
  logic              empty_out;
  logic              almost_full;
  logic              almost_empty;
  logic [CNT_W-1:0]  count;
  logic              flush;
  logic              clr_err;
  logic              overflow;
  logic              underflow;

  modport master (
    output req_put, data_put, req_get, flush, clr_err,
    input  data_get, valid_get, full_out, empty_out, almost_full,
           almost_empty, count, overflow, underflow
  );

  modport slave (
    input  req_put, data_put, req_get, flush, clr_err,
    output data_get, valid_get, full_out, empty_out, almost_full,
           almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_ram.sv
// Storage array of the FIFO: N_CELLS x N_BITS, one write port and one
// registered read port.
//   clk, reset : clock and synchronous active-high reset (read register only)
//   we_i/waddr_i/wdata_i : write enable, address, data
//   re_i/raddr_i         : read enable and address; rdata_o updates on the edge
//   rdata_o              : registered read data, holds when re_i is low
module fifo_ram #(
  parameter int N_BITS  = 32,
  parameter int N_CELLS = 16,
  parameter int PTR_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_i,
  input  logic [PTR_W-1:0]  waddr_i,
  input  logic [N_BITS-1:0] wdata_i,
  input  logic              re_i,
  input  logic [PTR_W-1:0]  raddr_i,
  output logic [N_BITS-1:0] rdata_o
);

  logic [N_BITS-1:0] mem_q [N_CELLS];
  logic [N_BITS-1:0] rdata_q;

  // NOTE: the array has no reset; stale contents are never visible because
  // the pointers and count gate every read, and a reset would block RAM mapping.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (reset)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/empty
// flags, synchronous flush and sticky overflow/underflow flags.
//   clk, reset : clock and synchronous active-high reset
//   bus        : slave side of fifo_sync_param_if (requests in, data/flags out)
// A get accepted on edge N is read from the array on edge N+1, so data_get and
// valid_get present that word after edge N+1. All outputs are registered.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int N_BITS    = 32,
  parameter int N_CELLS   = 16,
  parameter int AF_MARGIN = 2,
  parameter int AE_MARGIN = 2
) (
  input  logic               clk,
  input  logic               reset,
  fifo_sync_param_if.slave   bus
);

  localparam int CNT_W = cnt_w(N_CELLS);
  localparam int PTR_W = ptr_w(N_CELLS);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N_CELLS);
  localparam logic [CNT_W-1:0] AF_LVL   = CNT_W'(N_CELLS - AF_MARGIN);
  localparam logic [CNT_W-1:0] AE_LVL   = CNT_W'(AE_MARGIN);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_CELLS - 1);

  if (!params_ok(N_BITS, N_CELLS, AF_MARGIN, AE_MARGIN)) begin : g_bad_params
    $error("fifo_sync_param: illegal N_BITS/N_CELLS/AF_MARGIN/AE_MARGIN");
  end

  // Depth need not be a power of two, so wrap explicitly at the last cell.
  function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  logic [PTR_W-1:0] wp_q, wp_d, rp_q, rp_d, rd_addr_q, rd_addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  fifo_flags_t      flags_q, flags_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             rd_pend_q, rd_pend_d, valid_q, valid_d;
  logic             put_ok, get_ok;
  logic [N_BITS-1:0] rd_data;

  // Acceptance looks only at registered flags: no full/empty bypass.
  assign put_ok = bus.req_put & ~flags_q.full;
  assign get_ok = bus.req_get & ~flags_q.empty;

  // NOTE: every always_comb output gets its hold value first, so no branch
  // can leave one unassigned and infer a latch.
  always_comb begin
    wp_d      = wp_q;
    rp_d      = rp_q;
    cnt_d     = cnt_q;
    rd_addr_d = rp_q;
    rd_pend_d = get_ok;
    valid_d   = rd_pend_q;
    // Set wins over clear; flush leaves the error flags alone.
    ovf_d = (bus.req_put & flags_q.full)  | (ovf_q & ~bus.clr_err);
    unf_d = (bus.req_get & flags_q.empty) | (unf_q & ~bus.clr_err);

    if (bus.flush) begin
      wp_d      = '0;
      rp_d      = '0;
      cnt_d     = '0;
      rd_pend_d = 1'b0;
      valid_d   = 1'b0;
    end else begin
      if (put_ok) wp_d = inc_ptr(wp_q);
      if (get_ok) rp_d = inc_ptr(rp_q);
      case ({put_ok, get_ok})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end

    // Flags come from the next count so they are exact right after the edge.
    flags_d.full         = (cnt_d == CNT_FULL);
    flags_d.empty        = (cnt_d == '0);
    flags_d.almost_full  = (cnt_d >= AF_LVL);
    flags_d.almost_empty = (cnt_d <= AE_LVL);
  end

  // NOTE: state registers use non-blocking assignment so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q      <= '0;
      rp_q      <= '0;
      rd_addr_q <= '0;
      cnt_q     <= '0;
      flags_q   <= FLAGS_RST;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      rd_pend_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      rd_addr_q <= rd_addr_d;
      cnt_q     <= cnt_d;
      flags_q   <= flags_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      rd_pend_q <= rd_pend_d;
      valid_q   <= valid_d;
    end
  end

  fifo_ram #(
    .N_BITS  (N_BITS),
    .N_CELLS (N_CELLS),
    .PTR_W   (PTR_W)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .we_i    (put_ok & ~bus.flush),
    .waddr_i (wp_q),
    .wdata_i (bus.data_put),
    .re_i    (rd_pend_q & ~bus.flush),
    .raddr_i (rd_addr_q),
    .rdata_o (rd_data)
  );

  assign bus.data_get     = rd_data;
  assign bus.valid_get    = valid_q;
  assign bus.count        = cnt_q;
  assign bus.full_out     = flags_q.full;
  assign bus.empty_out    = flags_q.empty;
  assign bus.almost_full  = flags_q.almost_full;
  assign bus.almost_empty = flags_q.almost_empty;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Bench for fifo_sync_param: a 16x32 instance and a 5x8 instance run side by
// side, each compared every cycle against a queue-based model of the FIFO
// rules, with directed scenarios followed by randomized traffic.
module tb_fifo_sync_param;
  import fifo_pkg::*;

  localparam int CW16 = cnt_w(16);
  localparam int CW5  = cnt_w(5);

  typedef struct packed {
    logic        rp;
    logic [31:0] dp;
    logic        rg;
    logic        fl;
    logic        ce;
  } stim_t;

  localparam stim_t IDLE = '0;

  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fifo_sync_param_if #(.N_BITS(32), .CNT_W(CW16)) bus16 ();
  fifo_sync_param_if #(.N_BITS(8),  .CNT_W(CW5))  bus5 ();

  fifo_sync_param #(.N_BITS(32), .N_CELLS(16), .AF_MARGIN(2), .AE_MARGIN(2)) dut16 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus16)
  );

  fifo_sync_param #(.N_BITS(8), .N_CELLS(5), .AF_MARGIN(2), .AE_MARGIN(2)) dut5 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus5)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: a queue of stored words per FIFO plus the read pipeline.
  int          depth [2] = '{16, 5};
  logic [31:0] mask  [2] = '{32'hFFFF_FFFF, 32'h0000_00FF};
  logic [31:0] q16 [$];
  logic [31:0] q5  [$];
  bit          ov [2];
  bit          un [2];
  bit          vld[2];
  bit          pv [2];
  logic [31:0] dg [2];
  logic [31:0] pd [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int qsize(input int s);
    return (s == 0) ? q16.size() : q5.size();
  endfunction

  function automatic void qpush(input int s, input logic [31:0] v);
    if (s == 0) q16.push_back(v);
    else        q5.push_back(v);
  endfunction

  function automatic logic [31:0] qpop(input int s);
    return (s == 0) ? q16.pop_front() : q5.pop_front();
  endfunction

  function automatic void qclear(input int s);
    if (s == 0) q16.delete();
    else        q5.delete();
  endfunction

  function automatic stim_t mk(input logic rp, input logic [31:0] dp, input logic rg,
                               input logic fl, input logic ce);
    stim_t st;
    st.rp = rp; st.dp = dp; st.rg = rg; st.fl = fl; st.ce = ce;
    return st;
  endfunction

  task automatic model_edge(input int s, input stim_t st, input bit rst);
    bit full, empty;
    if (rst) begin
      qclear(s);
      ov[s] = 0; un[s] = 0; vld[s] = 0; pv[s] = 0; dg[s] = '0; pd[s] = '0;
      return;
    end
    full  = (qsize(s) == depth[s]);
    empty = (qsize(s) == 0);
    if (st.rp && full) ov[s] = 1; else if (st.ce) ov[s] = 0;
    if (st.rg && empty) un[s] = 1; else if (st.ce) un[s] = 0;
    if (st.fl) begin
      qclear(s);
      vld[s] = 0;
      pv[s]  = 0;
    end else begin
      vld[s] = pv[s];
      if (pv[s]) dg[s] = pd[s];
      pv[s] = st.rg && !empty;
      if (pv[s]) pd[s] = qpop(s);
      if (st.rp && !full) qpush(s, st.dp & mask[s]);
    end
  endtask

  task automatic check_dut(input int s);
    logic [31:0] o_data, o_cnt;
    logic o_valid, o_full, o_empty, o_af, o_ae, o_ov, o_un;
    string p;
    int n;
    if (s == 0) begin
      p = "d16_";
      o_data = bus16.data_get; o_cnt = 32'(bus16.count); o_valid = bus16.valid_get;
      o_full = bus16.full_out; o_empty = bus16.empty_out; o_af = bus16.almost_full;
      o_ae = bus16.almost_empty; o_ov = bus16.overflow; o_un = bus16.underflow;
    end else begin
      p = "d5_";
      o_data = 32'(bus5.data_get); o_cnt = 32'(bus5.count); o_valid = bus5.valid_get;
      o_full = bus5.full_out; o_empty = bus5.empty_out; o_af = bus5.almost_full;
      o_ae = bus5.almost_empty; o_ov = bus5.overflow; o_un = bus5.underflow;
    end
    n = qsize(s);
    check({p, "count"},        o_cnt,          32'(n));
    check({p, "full"},         32'(o_full),    32'(n == depth[s]));
    check({p, "empty"},        32'(o_empty),   32'(n == 0));
    check({p, "almost_full"},  32'(o_af),      32'(n >= depth[s] - 2));
    check({p, "almost_empty"}, 32'(o_ae),      32'(n <= 2));
    check({p, "overflow"},     32'(o_ov),      32'(ov[s]));
    check({p, "underflow"},    32'(o_un),      32'(un[s]));
    check({p, "valid_get"},    32'(o_valid),   32'(vld[s]));
    check({p, "data_get"},     o_data,         dg[s]);
  endtask

  // One clock: drive both FIFOs, advance the model on the edge, compare #1 later.
  task automatic step(input stim_t a, input stim_t b, input bit rst);
    reset          = rst;
    bus16.req_put  = a.rp; bus16.data_put = a.dp;      bus16.req_get = a.rg;
    bus16.flush    = a.fl; bus16.clr_err  = a.ce;
    bus5.req_put   = b.rp; bus5.data_put  = b.dp[7:0]; bus5.req_get  = b.rg;
    bus5.flush     = b.fl; bus5.clr_err   = b.ce;
    @(posedge clk);
    model_edge(0, a, rst);
    model_edge(1, b, rst);
    #1;
    check_dut(0);
    check_dut(1);
  endtask

  initial begin
    step(IDLE, IDLE, 1'b1);
    step(IDLE, IDLE, 1'b1);
    check("rst_empty", 32'(bus16.empty_out), 32'd1);
    check("rst_data",  bus16.data_get,       32'd0);

    // Fill 0x0..0xF, then drain and confirm order with one-cycle latency.
    for (int i = 0; i < 16; i++) step(mk(1'b1, 32'(i), 1'b0, 1'b0, 1'b0), IDLE, 1'b0);
    check("fill_full",  32'(bus16.full_out), 32'd1);
    check("fill_count", 32'(bus16.count),    32'd16);
    for (int i = 0; i <= 16; i++) begin
      step((i < 16) ? mk(1'b0, '0, 1'b1, 1'b0, 1'b0) : IDLE, IDLE, 1'b0);
      if (i >= 1) check("drain_data", bus16.data_get, 32'(i - 1));
    end
    check("drain_empty", 32'(bus16.empty_out), 32'd1);

    // Empty: simultaneous put+get -> put only, underflow set.
    step(mk(1'b1, 32'h100, 1'b1, 1'b0, 1'b0), IDLE, 1'b0);
    check("unf_count", 32'(bus16.count),     32'd1);
    check("unf_flag",  32'(bus16.underflow), 32'd1);
    check("unf_valid", 32'(bus16.valid_get), 32'd0);
    step(mk(1'b0, '0, 1'b0, 1'b0, 1'b1), IDLE, 1'b0);

    // Full: simultaneous put+get -> get only, overflow set, then cleared.
    for (int i = 1; i < 16; i++) step(mk(1'b1, 32'(32'h100 + i), 1'b0, 1'b0, 1'b0), IDLE, 1'b0);
    step(mk(1'b1, 32'hDEAD, 1'b1, 1'b0, 1'b0), IDLE, 1'b0);
    check("ovf_count", 32'(bus16.count),    32'd15);
    check("ovf_flag",  32'(bus16.overflow), 32'd1);
    step(mk(1'b0, '0, 1'b0, 1'b0, 1'b1), IDLE, 1'b0);
    check("ovf_clr",   32'(bus16.overflow), 32'd0);
    for (int i = 0; i < 16; i++) step(mk(1'b0, '0, 1'b1, 1'b0, 1'b0), IDLE, 1'b0);
    step(IDLE, IDLE, 1'b0);

    // Depth 5: 12 put/get pairs wrap both pointers with count held at 1.
    step(IDLE, mk(1'b1, 32'h40, 1'b0, 1'b0, 1'b0), 1'b0);
    for (int i = 0; i < 12; i++) begin
      step(IDLE, mk(1'b1, 32'(32'h41 + i), 1'b1, 1'b0, 1'b0), 1'b0);
      check("wrap_count", 32'(bus5.count), 32'd1);
    end
    step(IDLE, mk(1'b0, '0, 1'b1, 1'b0, 1'b0), 1'b0);
    step(IDLE, IDLE, 1'b0);

    // Flush at count 7 together with a put.
    for (int i = 0; i < 7; i++) step(mk(1'b1, 32'(32'h70 + i), 1'b0, 1'b0, 1'b0), IDLE, 1'b0);
    step(mk(1'b1, 32'h77, 1'b0, 1'b1, 1'b0), IDLE, 1'b0);
    check("flush_count", 32'(bus16.count),     32'd0);
    check("flush_empty", 32'(bus16.empty_out), 32'd1);
    check("flush_valid", 32'(bus16.valid_get), 32'd0);
    step(mk(1'b1, 32'hA5, 1'b0, 1'b0, 1'b0), IDLE, 1'b0);
    step(mk(1'b0, '0, 1'b1, 1'b0, 1'b0), IDLE, 1'b0);
    step(IDLE, IDLE, 1'b0);
    check("flush_readback", bus16.data_get, 32'hA5);

    // Reset mid-stream at count 9.
    for (int i = 0; i < 9; i++) step(mk(1'b1, 32'(32'h90 + i), 1'b0, 1'b0, 1'b0), IDLE, 1'b0);
    step(IDLE, IDLE, 1'b1);
    check("midrst_count", 32'(bus16.count),        32'd0);
    check("midrst_ae",    32'(bus16.almost_empty), 32'd1);
    step(IDLE, IDLE, 1'b0);

    // Randomized traffic, alternating put-heavy and get-heavy phases.
    for (int c = 0; c < 800; c++) begin
      stim_t a, b;
      int pp;
      pp = ((c / 100) % 2 == 0) ? 70 : 30;
      a = mk(1'($urandom_range(0, 99) < pp), $urandom, 1'($urandom_range(0, 99) < 100 - pp),
             1'($urandom_range(0, 99) < 2), 1'($urandom_range(0, 99) < 4));
      b = mk(1'($urandom_range(0, 99) < pp), $urandom, 1'($urandom_range(0, 99) < 100 - pp),
             1'($urandom_range(0, 99) < 2), 1'($urandom_range(0, 99) < 4));
      step(a, b, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_sync_param.md
# fifo_sync_param

Parametrised single-clock FIFO: the next-generation buffer for blocks whose producer and consumer share one clock. Generalises the 16-cell, 32-bit FIFO to any width and depth, and adds an occupancy count, programmable almost-full/almost-empty flags, a synchronous flush, and sticky overflow/underflow error flags. It sits between same-clock pipeline stages as an elastic buffer with put/get request handshakes.

## Interface
- N_BITS, 32, data width (≥1)
- N_CELLS, 16, depth in entries (≥2; need not be a power of two)
- AF_MARGIN, 2, almost_full asserts when count ≥ N_CELLS − AF_MARGIN (0 ≤ AF_MARGIN < N_CELLS)
- AE_MARGIN, 2, almost_empty asserts when count ≤ AE_MARGIN (0 ≤ AE_MARGIN < N_CELLS)

- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- req_put  in  1  write request
- data_put  in  N_BITS  write data, sampled with an accepted put
- req_get  in  1  read request
- data_get  out  N_BITS  registered read data
- valid_get  out  1  data_get holds the word from the get accepted on the previous edge
- full_out  out  1  count == N_CELLS
- empty_out  out  1  count == 0
- almost_full  out  1  see AF_MARGIN
- almost_empty  out  1  see AE_MARGIN
- count  out  CNT_W  occupancy; CNT_W = clog2(N_CELLS+1)
- flush  in  1  synchronous clear of contents
- clr_err  in  1  clears sticky error flags
- overflow  out  1  sticky: req_put seen while full_out
- underflow  out  1  sticky: req_get seen while empty_out

## Operation
- Accept rules, evaluated on current registered state: put_ok = req_put & ~full_out; get_ok = req_get & ~empty_out.
- A put is never accepted while full, even with a simultaneous get. A get is never accepted while empty, even with a simultaneous put. No bypass path.
- Storage: circular buffer with write pointer wp and read pointer rp, PTR_W = clog2(N_CELLS). Each pointer increments on its accept and wraps explicitly from N_CELLS−1 to 0.
- Count update: +1 on put_ok only; −1 on get_ok only; unchanged when both or neither occur.
- Flags are registered and computed from the next count, so they are valid immediately after the edge that changes the count.
- Flush has priority over put/get in the same cycle. It sets wp = rp = 0 and count = 0, empty_out = 1, full_out = 0, and valid_get = 0. Memory contents are not cleared. Error flags are unaffected.
- Errors: overflow sets on req_put & full_out; underflow sets on req_get & empty_out. Set has priority over clr_err in the same cycle. Rejected requests change no other state.
- Reset values: data_get = 0, valid_get = 0, count = 0, full_out = 0, empty_out = 1, almost_empty = 1, almost_full = 0, overflow = 0, underflow = 0, wp = rp = 0. Reset overrides flush and all requests.
- Reset or flush mid-stream discards all stored words. The first put after either lands in entry 0.

## Timing
- Read latency: 1 cycle. get_ok at edge N gives data_get and valid_get = 1 after edge N+1. valid_get drops the cycle after a get is not accepted; data_get holds its last value.
- Write-to-read: a word put at edge N is readable (empty_out = 0) after edge N. The earliest get_ok is at edge N+1, with data out after edge N+2.
- Sustained put/get every cycle at a nonzero, non-full level gives throughput of 1 word/cycle with constant count.
- No combinational path from req_put/req_get to any output.

## Structure
- Shared package fifo_pkg: clog2 function, CNT_W/PTR_W derivation helpers, parameter-legality checks (elaboration-time assertions on N_CELLS, AF_MARGIN, AE_MARGIN).
- One sub-module, fifo_ram: N_CELLS × N_BITS array with one write port and one registered read port. Control (pointers, count, flags, errors) stays in fifo_sync_param.

## Test plan
- Reset, then 16 puts of 0x0..0xF (N_CELLS = 16): full_out = 1 after the 16th, count = 16, almost_full from count 14; 16 gets return 0x0..0xF in order, one cycle after each get; empty_out = 1 after the last.
- When full, assert req_put and req_get together: get accepted, put rejected, count = 15, overflow = 1; clr_err clears it the next cycle.
- When empty, assert req_put and req_get together: put accepted, get rejected, count = 1, underflow = 1, valid_get = 0.
- With N_CELLS = 5, run 12 put/get pairs: pointers wrap past 4→0, data order is preserved, count stays at 1.
- With count = 7, assert flush together with req_put: count = 0, empty_out = 1, valid_get = 0; the next put of 0xA5 is read back as 0xA5.
- Assert reset mid-stream with count = 9: all outputs return to their reset values on the next edge.
